cga_rand_sampler: RTL and testbench
===================================

Name: cga_rand_sampler

Overview:
- Downstream consumer of the LFSR pseudo-random word in the CGA engine.
- Takes decimated snapshots of the LFSR output, slices each into FIELD_W-bit fields, and rejection-samples the fields against a runtime bound `limit`.
- Emits uniformly distributed values in [0, limit) over a valid/ready stream. Consumers are the mutation unit (gene/node index selection) and the parent-selection logic.

Parameters:
- LFSR_W, 107, width of the random word input (matches the LFSR width).
- FIELD_W, 7, width of each sampled field and of the output value.
- DECIM, 107, cycles between snapshots; must be ≥ LFSR_W so no bit is reused across snapshots of the one-bit-per-cycle shifter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- enable  in  1  run request from the CGA controller.
- rnd_valid  in  1  high while the LFSR is in its generate state.
- rnd  in  LFSR_W  LFSR result word.
- limit  in  FIELD_W  exclusive upper bound of output values.
- out_ready  in  1  downstream ready.
- out_valid  out  1  sample valid.
- out_value  out  FIELD_W  sampled value, always < captured limit.
- err_limit  out  1  high while in IDLE with enable=1 and limit=0.
- reject_cnt  out  16  saturating count of rejected fields (optional feature).
- sample_cnt  out  16  saturating count of accepted samples (optional feature).

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, out_valid=0, out_value=0, err_limit=0, counters=0, field_idx=0, decim_cnt=0, snapshot=0.
- NUM_FIELDS = LFSR_W / FIELD_W (floor; 15 at defaults). Top LFSR_W mod FIELD_W bits are unused.
- Field i = snap[i*FIELD_W +: FIELD_W].
- decim_cnt:
  - Increments every cycle rnd_valid=1; wraps at DECIM-1 (terminal tick).
  - Clears to 0 whenever rnd_valid=0 or state=IDLE.
- IDLE:
  - If enable=1 and limit≠0: capture limit_q=limit, go WAIT.
  - If enable=1 and limit=0: err_limit=1, stay IDLE.
- WAIT:
  - On terminal tick: snap<=rnd, field_idx<=0, go SCAN.
  - If enable=0: go IDLE.
- SCAN: compares one field per cycle; field_idx increments every SCAN cycle.
  - field < limit_q: out_value<=field, out_valid<=1, sample_cnt++, go OUT.
  - Otherwise: reject_cnt++. If this was field NUM_FIELDS-1, go WAIT.
  - If enable=0: go IDLE; the current field is discarded, not compared.
- OUT:
  - out_value and out_valid are held stable until out_valid&&out_ready.
  - On transfer: out_valid<=0. Go IDLE if enable=0; else WAIT if field_idx==NUM_FIELDS; else SCAN.
  - Deasserting enable never drops a pending sample.
- Each field is used at most once; a snapshot is never rescanned.
- Minimum accept latency: snap loads on the terminal tick; field 0 is compared the next cycle; out_valid is high the cycle after that.
- Throughput ceiling: one sample per 2 cycles within a snapshot.
- limit changes outside IDLE are ignored until the next IDLE exit.
- rnd_valid falling in WAIT: the block stays in WAIT with decim_cnt held at 0.
- rnd_valid falling in SCAN/OUT: no effect, since the snapshot is already captured.
- Counters saturate at 16'hFFFF.
- rst=0 mid-operation: full return to reset values at that edge; a pending sample is lost.

Optional Feature:
- Macro CGA_SAMPLER_STATS_EN.
- Defined: reject_cnt and sample_cnt are implemented as described, cleared only by reset.
- Undefined: both ports remain, tied to 0; no counter flops are synthesized.

Decomposition:
- Package cga_rng_pkg holds:
  - state encoding constants: IDLE, WAIT, SCAN, OUT;
  - the NUM_FIELDS computation as a constant function of LFSR_W/FIELD_W;
  - STAT_W=16.
- One sub-module, cga_field_select: combinational mux returning field field_idx of snap plus the (field < limit_q) accept flag, shared with the future crossover-point sampler.

Test Plan:
- Bench overrides DECIM=4 and drives rnd directly.
- rst=0 for 2 cycles, enable=1 → out_valid=0, out_value=0, err_limit=0, counters 0.
- limit=100, all fields=7'h05, out_ready=1 → 15 samples of 5 per snapshot, then a WAIT gap until the next terminal tick; reject_cnt=0.
- limit=10, even fields=7'h7F, odd fields=7'h03 → exactly 7 outputs of 3 per snapshot; reject_cnt increases by 8 per snapshot.
- Hold out_ready=0 for 20 cycles after the first out_valid → out_value stable; reject_cnt and sample_cnt unchanged; one transfer when out_ready rises.
- limit=0 with enable=1 → err_limit=1, out_valid never asserts. Then limit=5 → err_limit=0 and sampling starts.
- Drop enable during OUT → the sample still transfers, then IDLE. Assert rst=0 mid-SCAN → all outputs are reset values on the next edge.

Source files
------------

// File: rtl/cga_rand_sampler_pkg.sv
// Shared types and constants for the CGA random sampler and related samplers.
package cga_rng_pkg;

  localparam int unsigned STAT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SCAN = 2'd2,
    OUT  = 2'd3
  } state_t;

  // Number of whole fields that fit in one random word; leftover top bits go unused.
  function automatic int unsigned num_fields(input int unsigned lfsr_w, input int unsigned field_w);
    return lfsr_w / field_w;
  endfunction

endpackage

// File: rtl/cga_rand_sampler_if.sv
// Control, random-word input and output stream of the CGA random sampler.
interface cga_rand_sampler_if #(
  parameter int unsigned LFSR_W  = 107,
  parameter int unsigned FIELD_W = 7
);
  import cga_rng_pkg::*;

  logic                enable;
  logic                rnd_valid;
  logic [LFSR_W-1:0]   rnd;
  logic [FIELD_W-1:0]  limit;
  logic                out_ready;
  logic                out_valid;
  logic [FIELD_W-1:0]  out_value;
  logic                err_limit;
  logic [STAT_W-1:0]   reject_cnt;
  logic [STAT_W-1:0]   sample_cnt;

  modport master (
    output enable, rnd_valid, rnd, limit, out_ready,
    input  out_valid, out_value, err_limit, reject_cnt, sample_cnt
  );

  modport slave (
    input  enable, rnd_valid, rnd, limit, out_ready,
    output out_valid, out_value, err_limit, reject_cnt, sample_cnt
  );

endinterface

// File: rtl/cga_rand_sampler_field_select.sv
// Picks one field out of a captured snapshot and flags whether it is below the bound.
module cga_field_select #(
  parameter int unsigned FIELD_W    = 7,
  parameter int unsigned NUM_FIELDS = 15,
  parameter int unsigned IDX_W      = 4
) (
  input  logic [NUM_FIELDS*FIELD_W-1:0] i_snap,
  input  logic [IDX_W-1:0]              i_field_idx,
  input  logic [FIELD_W-1:0]            i_limit,
  output logic [FIELD_W-1:0]            o_field_c,
  output logic                          o_accept_c
);

  // Field mux; out-of-range indices read as zero.
  always_comb begin
    o_field_c = '0;
    for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
      if (i_field_idx == IDX_W'(i)) o_field_c = i_snap[i*FIELD_W +: FIELD_W];
    end
  end

  assign o_accept_c = (o_field_c < i_limit);

endmodule

// File: rtl/cga_rand_sampler.sv
// Rejection sampler: decimated LFSR snapshots sliced into fields, emitting values in [0, limit).
// Optional statistics counters are built when CGA_SAMPLER_STATS_EN is defined.
module cga_rand_sampler
  import cga_rng_pkg::*;
#(
  parameter int unsigned LFSR_W  = 107,
  parameter int unsigned FIELD_W = 7,
  parameter int unsigned DECIM   = 107
) (
  input logic               i_clk,
  input logic               i_rst,
  cga_rand_sampler_if.slave io_bus
);

  localparam int unsigned NUM_FIELDS = num_fields(LFSR_W, FIELD_W);
  localparam int unsigned USED_W     = NUM_FIELDS * FIELD_W;
  localparam int unsigned IDX_W      = $clog2(NUM_FIELDS + 1);
  localparam int unsigned DCNT_W     = $clog2(DECIM + 1);

  state_t              r_state;
  logic [USED_W-1:0]   r_snap;
  logic [IDX_W-1:0]    r_field_idx;
  logic [DCNT_W-1:0]   r_decim_cnt;
  logic [FIELD_W-1:0]  r_limit_q;
  logic [FIELD_W-1:0]  r_out_value;
  logic                r_out_valid;
  logic                r_err_limit;

  logic [FIELD_W-1:0]  w_field;
  logic                w_accept;
  logic                w_tick;
  logic                w_xfer;
  logic                w_last_field;

  assign w_tick       = io_bus.rnd_valid && (r_decim_cnt == DCNT_W'(DECIM - 1));
  assign w_xfer       = r_out_valid && io_bus.out_ready;
  assign w_last_field = (r_field_idx == IDX_W'(NUM_FIELDS - 1));

  // Bits above the last whole field never reach the sampler.
  if (LFSR_W > USED_W) begin : g_unused_rnd
    logic w_unused_rnd;
    assign w_unused_rnd = ^io_bus.rnd[LFSR_W-1:USED_W];
  end

  cga_field_select #(
    .FIELD_W    (FIELD_W),
    .NUM_FIELDS (NUM_FIELDS),
    .IDX_W      (IDX_W)
  ) u_field_select (
    .i_snap      (r_snap),
    .i_field_idx (r_field_idx),
    .i_limit     (r_limit_q),
    .o_field_c   (w_field),
    .o_accept_c  (w_accept)
  );

  // Decimation counter: free-runs while the LFSR is generating and the sampler is active.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_decim_cnt <= '0;
    end else if (!io_bus.rnd_valid || (r_state == IDLE) || w_tick) begin
      r_decim_cnt <= '0;
    end else begin
      r_decim_cnt <= r_decim_cnt + DCNT_W'(1);
    end
  end

  // Sampler FSM with registered stream outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= IDLE;
      r_snap      <= '0;
      r_field_idx <= '0;
      r_limit_q   <= '0;
      r_out_value <= '0;
      r_out_valid <= 1'b0;
      r_err_limit <= 1'b0;
    end else begin
      r_err_limit <= 1'b0;
      case (r_state)
        IDLE: begin
          r_err_limit <= io_bus.enable && (io_bus.limit == '0);
          if (io_bus.enable && (io_bus.limit != '0)) begin
            r_limit_q <= io_bus.limit;
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          if (!io_bus.enable) begin
            r_state <= IDLE;
          end else if (w_tick) begin
            r_snap      <= io_bus.rnd[USED_W-1:0];
            r_field_idx <= '0;
            r_state     <= SCAN;
          end
        end
        SCAN: begin
          if (!io_bus.enable) begin
            r_state <= IDLE;
          end else begin
            r_field_idx <= r_field_idx + IDX_W'(1);
            if (w_accept) begin
              r_out_value <= w_field;
              r_out_valid <= 1'b1;
              r_state     <= OUT;
            end else if (w_last_field) begin
              r_state <= WAIT;
            end
          end
        end
        OUT: begin
          if (w_xfer) begin
            r_out_valid <= 1'b0;
            if (!io_bus.enable)                             r_state <= IDLE;
            else if (r_field_idx == IDX_W'(NUM_FIELDS))     r_state <= WAIT;
            else                                            r_state <= SCAN;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_value = r_out_value;
  assign io_bus.err_limit = r_err_limit;

`ifdef CGA_SAMPLER_STATS_EN
  logic [STAT_W-1:0] r_reject_cnt;
  logic [STAT_W-1:0] r_sample_cnt;
  logic              w_scan_cmp;

  assign w_scan_cmp = (r_state == SCAN) && io_bus.enable;

  // Saturating accept/reject statistics, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_reject_cnt <= '0;
      r_sample_cnt <= '0;
    end else begin
      if (w_scan_cmp && !w_accept && (r_reject_cnt != '1)) r_reject_cnt <= r_reject_cnt + STAT_W'(1);
      if (w_scan_cmp && w_accept && (r_sample_cnt != '1))  r_sample_cnt <= r_sample_cnt + STAT_W'(1);
    end
  end

  assign io_bus.reject_cnt = r_reject_cnt;
  assign io_bus.sample_cnt = r_sample_cnt;
`else
  assign io_bus.reject_cnt = '0;
  assign io_bus.sample_cnt = '0;
`endif

endmodule

// File: tb/tb_cga_rand_sampler.sv
// Directed bench for cga_rand_sampler with DECIM shortened to 4.
module tb_cga_rand_sampler;

  localparam int unsigned LFSR_W  = 107;
  localparam int unsigned FIELD_W = 7;
  localparam int unsigned DECIM   = 4;
  localparam int unsigned NF      = 15;
`ifdef CGA_SAMPLER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic [6:0] limit;
    logic [6:0] ev;
    logic [6:0] od;
    int         n_acc;
    int         n_rej;
    logic [6:0] exp_val;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cga_rand_sampler_if #(.LFSR_W(LFSR_W), .FIELD_W(FIELD_W)) bus();

  cga_rand_sampler #(.LFSR_W(LFSR_W), .FIELD_W(FIELD_W), .DECIM(DECIM)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  int         errors = 0;
  int         checks = 0;
  int         xfers  = 0;
  logic [6:0] exp_val = '0;
  vec_t       tbl [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] cnt_exp(input int n);
    return STATS ? 64'(n) : 64'd0;
  endfunction

  function automatic logic [LFSR_W-1:0] mk_snap(input logic [6:0] ev, input logic [6:0] od);
    logic [LFSR_W-1:0] s;
    s = '1;
    for (int i = 0; i < int'(NF); i++) s[i*7 +: 7] = (i % 2 == 0) ? ev : od;
    return s;
  endfunction

  // One clock: note a transfer happening at the coming edge, land on the next falling edge.
  task automatic step();
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      xfers++;
      check("xfer_value", 64'(bus.out_value), 64'(exp_val));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Two clock edges with reset low; leaves reset asserted.
  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    xfers = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"},  64'(bus.out_valid),  64'd0);
    check({tag, "_value"},  64'(bus.out_value),  64'd0);
    check({tag, "_err"},    64'(bus.err_limit),  64'd0);
    check({tag, "_rejcnt"}, 64'(bus.reject_cnt), 64'd0);
    check({tag, "_smpcnt"}, 64'(bus.sample_cnt), 64'd0);
  endtask

  initial begin
    bit stable;
    bit seen;
    int bound;
    logic [6:0] held;

    tbl[0] = '{7'd100, 7'h05, 7'h05, 15, 0, 7'h05};
    tbl[1] = '{7'd10,  7'h7F, 7'h03, 7,  8, 7'h03};
    tbl[2] = '{7'd64,  7'h3F, 7'h40, 8,  7, 7'h3F};
    tbl[3] = '{7'd1,   7'h00, 7'h00, 15, 0, 7'h00};
    tbl[4] = '{7'd127, 7'h7F, 7'h7E, 7,  8, 7'h7E};

    rst           = 1'b0;
    bus.enable    = 1'b1;
    bus.rnd_valid = 1'b1;
    bus.limit     = 7'd100;
    bus.rnd       = mk_snap(7'h05, 7'h05);
    bus.out_ready = 1'b1;
    exp_val       = 7'h05;

    // Reset values, then first-sample latency and back-pressure.
    do_reset();
    check_reset_vals("rst");
    rst = 1'b1;
    for (int c = 0; c < 5; c++) step();
    check("lat_valid_pre", 64'(bus.out_valid), 64'd0);
    step();
    check("lat_valid", 64'(bus.out_valid), 64'd1);
    check("lat_value", 64'(bus.out_value), 64'd5);
    bus.out_ready = 1'b0;
    held   = bus.out_value;
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.out_valid !== 1'b1 || bus.out_value !== held) stable = 1'b0;
    end
    check("hold_stable", 64'(stable), 64'd1);
    check("hold_smpcnt", 64'(bus.sample_cnt), cnt_exp(1));
    check("hold_rejcnt", 64'(bus.reject_cnt), cnt_exp(0));
    bus.out_ready = 1'b1;
    step();
    check("hold_xfers", 64'(xfers), 64'd1);
    check("hold_valid_after", 64'(bus.out_valid), 64'd0);

    // Table: one snapshot in a fixed window, then a second snapshot.
    for (int v = 0; v < 5; v++) begin
      bus.limit     = tbl[v].limit;
      bus.rnd       = mk_snap(tbl[v].ev, tbl[v].od);
      bus.enable    = 1'b1;
      bus.rnd_valid = 1'b1;
      bus.out_ready = 1'b1;
      exp_val       = tbl[v].exp_val;
      do_reset();
      rst = 1'b1;
      for (int c = 0; c < 5 + tbl[v].n_rej + 2 * tbl[v].n_acc + 1; c++) step();
      check("snap1_xfers",  64'(xfers),          64'(tbl[v].n_acc));
      check("snap1_smpcnt", 64'(bus.sample_cnt), cnt_exp(tbl[v].n_acc));
      check("snap1_rejcnt", 64'(bus.reject_cnt), cnt_exp(tbl[v].n_rej));
      bound = 0;
      while (xfers < 2 * tbl[v].n_acc && bound < 200) begin
        step();
        bound++;
      end
      check("snap2_xfers", 64'(xfers), 64'(2 * tbl[v].n_acc));
      step();
      check("snap2_smpcnt", 64'(bus.sample_cnt), cnt_exp(2 * tbl[v].n_acc));
      check("snap2_rejcnt", 64'(bus.reject_cnt), cnt_exp(2 * tbl[v].n_rej));
    end

    // limit=0 error, then recovery with limit=5.
    bus.enable    = 1'b1;
    bus.limit     = 7'd0;
    bus.rnd       = mk_snap(7'h02, 7'h02);
    bus.out_ready = 1'b0;
    exp_val       = 7'h02;
    do_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) step();
    check("lim0_err", 64'(bus.err_limit), 64'd1);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    check("lim0_novalid", 64'(seen), 64'd0);
    bus.limit = 7'd5;
    step();
    check("lim5_err", 64'(bus.err_limit), 64'd0);
    bound = 0;
    while (bus.out_valid !== 1'b1 && bound < 20) begin
      step();
      bound++;
    end
    check("lim5_valid", 64'(bus.out_valid), 64'd1);
    check("lim5_value", 64'(bus.out_value), 64'd2);

    // Dropping enable with a sample pending still delivers it.
    bus.enable = 1'b0;
    for (int c = 0; c < 3; c++) step();
    check("dis_pending_valid", 64'(bus.out_valid), 64'd1);
    check("dis_pending_value", 64'(bus.out_value), 64'd2);
    xfers = 0;
    bus.out_ready = 1'b1;
    step();
    check("dis_xfer", 64'(xfers), 64'd1);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus.out_valid !== 1'b0) seen = 1'b1;
      step();
    end
    check("dis_idle", 64'(seen), 64'd0);
    check("dis_smpcnt", 64'(bus.sample_cnt), cnt_exp(1));

    // Reset in the middle of a scan.
    bus.enable = 1'b1;
    bus.limit  = 7'd100;
    bus.rnd    = mk_snap(7'h05, 7'h05);
    exp_val    = 7'h05;
    do_reset();
    rst = 1'b1;
    for (int c = 0; c < 7; c++) step();
    check("mid_pre_value", 64'(bus.out_value), 64'd5);
    rst = 1'b0;
    step();
    check_reset_vals("mid_rst");

    // rnd_valid low holds the sampler in WAIT.
    bus.rnd_valid = 1'b0;
    do_reset();
    rst = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    check("rv_low_novalid", 64'(seen), 64'd0);
    bus.rnd_valid = 1'b1;
    for (int c = 0; c < 4; c++) step();
    check("rv_resume_pre", 64'(bus.out_valid), 64'd0);
    step();
    check("rv_resume_valid", 64'(bus.out_valid), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
